// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the music playback path.
//   note_t        4-bit note code from the sequencer (0x0..0xE = C4..D5, 0xF = rest)
//   NOTE_SILENCE  rest code
//   tone_state_t  playback FSM states
//   PITCH_HALF    square-wave half-periods in 50 MHz clock cycles, C4..D5 chromatic
//   pitch_half()  table lookup that yields 0 for the rest code
package audio_pkg;

  typedef logic [3:0] note_t;

  localparam note_t NOTE_SILENCE = 4'hF;

  typedef enum logic [1:0] {
    SILENT = 2'd0,
    TONE   = 2'd1,
    GAP    = 2'd2
  } tone_state_t;

  localparam logic [16:0] PITCH_HALF [0:14] = '{
    17'd95555, 17'd90194, 17'd85132, 17'd80352, 17'd75843,
    17'd71586, 17'd67569, 17'd63776, 17'd60197, 17'd56818,
    17'd53630, 17'd50620, 17'd47778, 17'd45096, 17'd42566
  };

  function automatic logic [16:0] pitch_half(input note_t n);
    if (n == NOTE_SILENCE) return 17'd0;
    return PITCH_HALF[n];
  endfunction

endpackage

// File: rtl/note_tone_gen_if.sv
// note_tone_gen_if: sequencer <-> tone generator signals.
//   run         1 = beat counter advances, 0 = frozen and silenced
//   note        note code from the sequencer
//   noteEnable  1 = note is to be sounded
//   switchNote  one-cycle beat pulse back to the sequencer
//   tone_out    square wave
//   sample      signed amplitude sample
//   busy        high while a tone is sounding
// master = sequencer / audio consumer side, slave = tone generator.
interface note_tone_gen_if;
  import audio_pkg::*;

  logic               run;
  note_t              note;
  logic               noteEnable;
  logic               switchNote;
  logic               tone_out;
  logic signed [7:0]  sample;
  logic               busy;

  modport master (
    output run, note, noteEnable,
    input  switchNote, tone_out, sample, busy
  );

  modport slave (
    input  run, note, noteEnable,
    output switchNote, tone_out, sample, busy
  );
endinterface

// File: rtl/note_tone_gen_beat_timer.sv
// beat_timer: 26-bit beat counter for the tone generator.
//   clk, reset   clock and synchronous active-high reset
//   run          1 = count advances, 0 = count holds
//   switch_note  high for the single cycle the count equals BEAT_DIV-1
//   gap_start    high for the single cycle the count equals BEAT_DIV-1-GAP_CYCLES
module beat_timer #(
  parameter int unsigned BEAT_DIV   = 12500000,
  parameter int unsigned GAP_CYCLES = 1250000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic switch_note,
  output logic gap_start
);

  localparam logic [25:0] LAST   = 26'(BEAT_DIV - 1);
  localparam logic [25:0] GAP_AT = 26'(BEAT_DIV - 1 - GAP_CYCLES);

  logic [25:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (run) begin
      count <= (count == LAST) ? '0 : count + 26'd1;
    end
  end

  // Decoded from the registered count, so both strobes are clean one-cycle pulses.
  assign switch_note = run && (count == LAST);
  assign gap_start   = run && (count == GAP_AT);

endmodule

// File: rtl/note_tone_gen.sv
// note_tone_gen: playback end of the in-game music path.
// Generates the beat pulse for the melody sequencer, latches the note it
// returns, and plays it as a square wave with a silent gap at the end of
// each beat.
//   clk    system clock (50 MHz)
//   reset  synchronous, active-high
//   bus    note_tone_gen_if.slave: run/note/noteEnable in,
//          switchNote/tone_out/sample/busy out
// Build option: TONE_ENVELOPE_EN adds a linear decay of the sample magnitude
// (one step every 2^16 >> DIV_SHIFT cycles in TONE, reloaded on each tone load).
module note_tone_gen
  import audio_pkg::*;
#(
  parameter int unsigned        BEAT_DIV   = 12500000,
  parameter int unsigned        GAP_CYCLES = 1250000,
  parameter int unsigned        DIV_SHIFT  = 0,
  parameter logic signed [7:0]  AMP        = 8'sd96
) (
  input  logic            clk,
  input  logic            reset,
  note_tone_gen_if.slave  bus
);

  logic               switch_note;
  logic               gap_start;
  logic               load_p1;
  tone_state_t        state;
  note_t              note_q;
  logic               en_q;
  logic [16:0]        phase_p1;
  logic               tone_p1;
  logic [16:0]        half;
  logic               tone_wrap;
  logic               sound_next;
  logic               note_live;
  logic signed [7:0]  mag;

  beat_timer #(
    .BEAT_DIV   (BEAT_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_beat_timer (
    .clk         (clk),
    .reset       (reset),
    .run         (bus.run),
    .switch_note (switch_note),
    .gap_start   (gap_start)
  );

  assign bus.switchNote = switch_note;

  assign half       = pitch_half(note_q) >> DIV_SHIFT;
  // >= rather than == so a smaller half after a reload can never run away.
  assign tone_wrap  = (phase_p1 >= half - 17'd1);
  // The sequencer presents the new note in the load cycle itself, so the
  // state decision uses the incoming values, not the latched ones.
  assign sound_next = bus.noteEnable && (bus.note != NOTE_SILENCE);
  assign note_live  = en_q && (note_q != NOTE_SILENCE);

`ifdef TONE_ENVELOPE_EN
  localparam int unsigned ENV_PERIOD = ((32'd1 << 16) >> DIV_SHIFT) == 0 ? 1 : ((32'd1 << 16) >> DIV_SHIFT);
  localparam logic [16:0] ENV_LAST   = 17'(ENV_PERIOD - 1);

  logic [16:0] env_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      mag     <= '0;
      env_cnt <= '0;
    end else if (bus.run && load_p1 && sound_next) begin
      mag     <= AMP;
      env_cnt <= '0;
    end else if (bus.run && state == TONE) begin
      if (env_cnt == ENV_LAST) begin
        env_cnt <= '0;
        if (mag != 8'sd0) mag <= mag - 8'sd1;
      end else begin
        env_cnt <= env_cnt + 17'd1;
      end
    end
  end
`else
  assign mag = AMP;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      load_p1      <= 1'b0;
      state        <= SILENT;
      note_q       <= '0;
      en_q         <= 1'b0;
      phase_p1     <= '0;
      tone_p1      <= 1'b0;
      bus.tone_out <= 1'b0;
      bus.sample   <= '0;
      bus.busy     <= 1'b0;
    end else begin
      // stage p1: beat pulse delayed to the cycle the new note is valid
      load_p1 <= switch_note;

      // stage p2: output pins follow the current state one cycle later
      if (bus.run && state == TONE) begin
        bus.tone_out <= tone_p1;
        bus.sample   <= tone_p1 ? mag : -mag;
        bus.busy     <= 1'b1;
      end else begin
        bus.tone_out <= 1'b0;
        bus.sample   <= '0;
        bus.busy     <= 1'b0;
      end

      if (!bus.run) begin
        state    <= SILENT;
        phase_p1 <= '0;
        tone_p1  <= 1'b0;
      end else if (load_p1) begin
        // Every load restarts the phase, so repeated notes re-articulate.
        note_q   <= bus.note;
        en_q     <= bus.noteEnable;
        phase_p1 <= '0;
        tone_p1  <= 1'b1;
        state    <= sound_next ? TONE : SILENT;
      end else begin
        case (state)
          TONE: begin
            if (!note_live)     state <= SILENT;
            else if (gap_start) state <= GAP;
            if (tone_wrap) begin
              phase_p1 <= '0;
              tone_p1  <= ~tone_p1;
            end else begin
              phase_p1 <= phase_p1 + 17'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_tone_gen.sv
// tb_note_tone_gen: directed bench for note_tone_gen with BEAT_DIV=1000,
// GAP_CYCLES=100, DIV_SHIFT=8, AMP=96. The bench keeps its own model of the
// beat position (pos) and checks outputs on the falling edge.
// With TONE_ENVELOPE_EN defined a second instance (BEAT_DIV=26000) checks the decay.
module tb_note_tone_gen;
  import audio_pkg::*;

  localparam int BEAT = 1000;
  localparam logic signed [7:0] PK = 8'sd96;
  localparam logic signed [7:0] NK = -8'sd96;

  logic clk = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;
  int   pos    = 0;

  always #5 clk = ~clk;

  note_tone_gen_if bus ();

  note_tone_gen #(
    .BEAT_DIV(BEAT), .GAP_CYCLES(100), .DIV_SHIFT(8), .AMP(8'sd96)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

`ifdef TONE_ENVELOPE_EN
  note_tone_gen_if ebus ();

  note_tone_gen #(
    .BEAT_DIV(26000), .GAP_CYCLES(100), .DIV_SHIFT(8), .AMP(8'sd96)
  ) dut_env (
    .clk(clk), .reset(reset), .bus(ebus)
  );
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock; pos follows what the beat counter should hold at this negedge.
  task automatic tick();
    if (reset) pos = 0;
    else if (bus.run) pos = (pos == BEAT - 1) ? 0 : pos + 1;
    @(negedge clk);
  endtask

  task automatic goto(input int target);
    int n = 0;
    while (pos != target && n < 2 * BEAT) begin
      tick();
      n++;
    end
    if (pos != target) begin
      total++;
      $display("FAIL goto: pos=%0d required %0d", pos, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.run = 1'b0; bus.note = NOTE_SILENCE; bus.noteEnable = 1'b0;
`ifdef TONE_ENVELOPE_EN
    ebus.run = 1'b0; ebus.note = NOTE_SILENCE; ebus.noteEnable = 1'b0;
`endif
    @(negedge clk);
    repeat (3) tick();
    total++;
    if ({bus.switchNote, bus.tone_out, bus.busy} !== 3'b000) $display("FAIL reset_flags: got %b required 000", {bus.switchNote, bus.tone_out, bus.busy});
    else passed++;
    total++;
    if (bus.sample !== 8'sd0) $display("FAIL reset_sample: got %0d required 0", bus.sample);
    else passed++;
    reset = 1'b0;
    bus.run = 1'b1;
`ifdef TONE_ENVELOPE_EN
    ebus.run = 1'b1;
`endif
  endtask

  task automatic test_beat_rate();
    int hits = 0, extra = 0, consec = 0, noisy = 0;
    logic prev = 1'b0;
    for (int c = 0; c < 3 * BEAT; c++) begin
      if (c > 0) tick();
      if (bus.switchNote === 1'b1) begin
        if (c == 999 || c == 1999 || c == 2999) hits++;
        else extra++;
        if (prev) consec++;
      end
      if (bus.busy !== 1'b0 || bus.sample !== 8'sd0) noisy++;
      prev = bus.switchNote;
    end
    total++; if (hits !== 3) $display("FAIL beat_hits: got %0d required 3", hits); else passed++;
    total++; if (extra !== 0) $display("FAIL beat_extra: got %0d required 0", extra); else passed++;
    total++; if (consec !== 0) $display("FAIL beat_consec: got %0d required 0", consec); else passed++;
    total++; if (noisy !== 0) $display("FAIL beat_quiet: got %0d noisy cycles required 0", noisy); else passed++;
  endtask

  task automatic test_pitch_low();
    goto(999); bus.note = 4'h0; bus.noteEnable = 1'b1;
    goto(1);
    total++; if (bus.sample !== 8'sd0) $display("FAIL low_latency: got %0d required 0", bus.sample); else passed++;
    goto(2);
    total++; if ({bus.tone_out, bus.busy} !== 2'b11 || bus.sample !== PK) $display("FAIL low_start: got %b/%0d required 11/96", {bus.tone_out, bus.busy}, bus.sample); else passed++;
    goto(374);
    total++; if (bus.tone_out !== 1'b1) $display("FAIL low_374: got %b required 1", bus.tone_out); else passed++;
    goto(375);
    total++; if (bus.tone_out !== 1'b0 || bus.sample !== NK) $display("FAIL low_375: got %b/%0d required 0/-96", bus.tone_out, bus.sample); else passed++;
    goto(748);
    total++; if (bus.tone_out !== 1'b1 || bus.sample !== PK) $display("FAIL low_748: got %b/%0d required 1/96", bus.tone_out, bus.sample); else passed++;
  endtask

  task automatic test_gap();
    int noisy = 0;
    goto(900);
    total++; if (bus.busy !== 1'b1) $display("FAIL gap_900: busy got %b required 1", bus.busy); else passed++;
    goto(901);
    total++; if (bus.busy !== 1'b0 || bus.sample !== 8'sd0) $display("FAIL gap_901: got %b/%0d required 0/0", bus.busy, bus.sample); else passed++;
    while (pos != 999) begin
      tick();
      if (bus.busy !== 1'b0 || bus.sample !== 8'sd0 || bus.tone_out !== 1'b0) noisy++;
    end
    total++; if (noisy !== 0) $display("FAIL gap_tail: got %0d noisy cycles required 0", noisy); else passed++;
  endtask

  task automatic test_pitch_high();
    goto(999); bus.note = 4'hE; bus.noteEnable = 1'b1;
    goto(167);
    total++; if (bus.tone_out !== 1'b1) $display("FAIL high_167: got %b required 1", bus.tone_out); else passed++;
    goto(168);
    total++; if (bus.tone_out !== 1'b0 || bus.sample !== NK) $display("FAIL high_168: got %b/%0d required 0/-96", bus.tone_out, bus.sample); else passed++;
    goto(334);
    total++; if (bus.tone_out !== 1'b1 || bus.sample !== PK) $display("FAIL high_334: got %b/%0d required 1/96", bus.tone_out, bus.sample); else passed++;
  endtask

  task automatic test_silence();
    int noisy;
    goto(999); bus.note = NOTE_SILENCE; bus.noteEnable = 1'b1;
    noisy = 0;
    do begin
      tick();
      if (bus.busy !== 1'b0 || bus.sample !== 8'sd0) noisy++;
    end while (pos != 999);
    total++; if (noisy !== 0) $display("FAIL silence_F: got %0d noisy cycles required 0", noisy); else passed++;
    bus.note = 4'h7; bus.noteEnable = 1'b0;
    noisy = 0;
    do begin
      tick();
      if (bus.busy !== 1'b0 || bus.sample !== 8'sd0) noisy++;
    end while (pos != 999);
    total++; if (noisy !== 0) $display("FAIL silence_en0: got %0d noisy cycles required 0", noisy); else passed++;
  endtask

  task automatic test_back_to_back();
    goto(999); bus.note = 4'h7; bus.noteEnable = 1'b1;
    goto(2);
    total++; if (bus.sample !== PK) $display("FAIL b2b_first: got %0d required 96", bus.sample); else passed++;
    goto(999);
    goto(1);
    total++; if (bus.busy !== 1'b0 || bus.sample !== 8'sd0) $display("FAIL b2b_gap: got %b/%0d required 0/0", bus.busy, bus.sample); else passed++;
    goto(2);
    total++; if (bus.busy !== 1'b1 || bus.sample !== PK) $display("FAIL b2b_restart: got %b/%0d required 1/96", bus.busy, bus.sample); else passed++;
    goto(250);
    total++; if (bus.tone_out !== 1'b1) $display("FAIL b2b_250: got %b required 1", bus.tone_out); else passed++;
    goto(251);
    total++; if (bus.tone_out !== 1'b0 || bus.sample !== NK) $display("FAIL b2b_251: got %b/%0d required 0/-96", bus.tone_out, bus.sample); else passed++;
  endtask

  task automatic test_reset_mid();
    goto(300);
    total++; if (bus.busy !== 1'b1 || bus.sample !== NK) $display("FAIL rmid_pre: got %b/%0d required 1/-96", bus.busy, bus.sample); else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if ({bus.switchNote, bus.tone_out, bus.busy} !== 3'b000 || bus.sample !== 8'sd0) $display("FAIL rmid_out: got %b/%0d required 000/0", {bus.switchNote, bus.tone_out, bus.busy}, bus.sample); else passed++;
    goto(500);
    total++; if (bus.busy !== 1'b0 || bus.sample !== 8'sd0) $display("FAIL rmid_silent: got %b/%0d required 0/0", bus.busy, bus.sample); else passed++;
    goto(998);
    total++; if (bus.switchNote !== 1'b0) $display("FAIL rmid_998: got %b required 0", bus.switchNote); else passed++;
    tick();
    total++; if (bus.switchNote !== 1'b1) $display("FAIL rmid_999: got %b required 1", bus.switchNote); else passed++;
  endtask

  task automatic test_run_pause();
    int noisy = 0;
    goto(999); bus.note = 4'h7; bus.noteEnable = 1'b1;
    goto(100);
    total++; if (bus.busy !== 1'b1) $display("FAIL pause_pre: busy got %b required 1", bus.busy); else passed++;
    bus.run = 1'b0;
    repeat (500) begin
      tick();
      if (bus.switchNote !== 1'b0 || bus.busy !== 1'b0 || bus.sample !== 8'sd0) noisy++;
    end
    total++; if (noisy !== 0) $display("FAIL pause_quiet: got %0d noisy cycles required 0", noisy); else passed++;
    bus.run = 1'b1;
    goto(998);
    total++; if (bus.switchNote !== 1'b0 || bus.sample !== 8'sd0) $display("FAIL pause_998: got %b/%0d required 0/0", bus.switchNote, bus.sample); else passed++;
    tick();
    total++; if (bus.switchNote !== 1'b1) $display("FAIL pause_999: got %b required 1", bus.switchNote); else passed++;
  endtask

`ifdef TONE_ENVELOPE_EN
  task automatic test_envelope();
    int n = 0;
    int s;
    ebus.note = 4'h0; ebus.noteEnable = 1'b1;
    while (ebus.busy !== 1'b1 && n < 60000) begin @(negedge clk); n++; end
    s = ebus.sample; if (s < 0) s = -s;
    total++; if (s !== 96) $display("FAIL env_start: got %0d required 96", s); else passed++;
    repeat (255) @(negedge clk);
    s = ebus.sample; if (s < 0) s = -s;
    total++; if (s !== 96) $display("FAIL env_255: got %0d required 96", s); else passed++;
    @(negedge clk);
    s = ebus.sample; if (s < 0) s = -s;
    total++; if (s !== 95) $display("FAIL env_256: got %0d required 95", s); else passed++;
    repeat (24575 - 256) @(negedge clk);
    s = ebus.sample; if (s < 0) s = -s;
    total++; if (s !== 1) $display("FAIL env_24575: got %0d required 1", s); else passed++;
    @(negedge clk);
    total++; if (ebus.sample !== 8'sd0) $display("FAIL env_zero: got %0d required 0", ebus.sample); else passed++;
    repeat (400) @(negedge clk);
    total++; if (ebus.sample !== 8'sd0 || ebus.busy !== 1'b1) $display("FAIL env_hold: got %0d/%b required 0/1", ebus.sample, ebus.busy); else passed++;
    n = 0;
    while (ebus.busy !== 1'b0 && n < 30000) begin @(negedge clk); n++; end
    n = 0;
    while (ebus.busy !== 1'b1 && n < 30000) begin @(negedge clk); n++; end
    s = ebus.sample; if (s < 0) s = -s;
    total++; if (s !== 96) $display("FAIL env_reload: got %0d required 96", s); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_beat_rate();
    test_pitch_low();
    test_gap();
    test_pitch_high();
    test_silence();
    test_back_to_back();
    test_reset_mid();
    test_run_pause();
`ifdef TONE_ENVELOPE_EN
    test_envelope();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
